// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: byte/status bus between the UART receiver and its holding-register consumer.
interface uart_rx_deser_if;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       rx_done;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic       rx_read;
    logic       clr_err;
    modport master (output rx_byte, rx_ready, rx_done, parity_err, framing_err, overflow,
                    input rx_read, clr_err);
    modport slave  (input rx_byte, rx_ready, rx_done, parity_err, framing_err, overflow,
                    output rx_read, clr_err);
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 16x-oversampled UART receiver with 7/8-bit data, optional parity and
// sticky parity/framing/overflow status.
module uart_rx_deser #(
    parameter int SYNC_STAGES = 2,
    parameter bit MAJORITY    = 1
) (
    input  logic clk,
    input  logic aresetn,
    input  logic baud_x16,
    input  logic rx,
    input  logic bit8,
    input  logic parity_en,
    input  logic odd_n_even,
    uart_rx_deser_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic [1:0] hist;
    logic [3:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic f_bit8, f_par, f_odd, perr;
    logic rx_s, smp, last_bit, stop_pt, load;
    assign rx_s     = sync[SYNC_STAGES-1];
    // hist holds the two previous tick samples, so with the live rx_s it covers counts 13..15 (or 5..7)
    assign smp      = MAJORITY ? ((hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s)) : rx_s;
    assign last_bit = bit_cnt == (f_bit8 ? 3'd7 : 3'd6);
    assign stop_pt  = baud_x16 && state == STOP && cnt == 4'd15;
    assign load     = stop_pt && !(bus.rx_ready && !bus.rx_read);
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) sync <= '1;
        else          sync <= {sync[SYNC_STAGES-2:0], rx};
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    always_comb begin
        state_nx = state;
        if (baud_x16)
            case (state)
                IDLE:     if (!rx_s) state_nx = START;
                START:    if (cnt == 4'd7) state_nx = smp ? IDLE : DATA;
                DATA:     if (cnt == 4'd15 && last_bit) state_nx = f_par ? PARITY : STOP;
                PARITY:   if (cnt == 4'd15) state_nx = STOP;
                STOP:     if (cnt == 4'd15) state_nx = smp ? IDLE : BRK_WAIT;
                BRK_WAIT: if (rx_s) state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            hist            <= '0;
            cnt             <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            {f_bit8, f_par, f_odd, perr} <= '0;
            bus.rx_byte     <= '0;
            bus.rx_ready    <= 1'b0;
            bus.rx_done     <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.framing_err <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            if (baud_x16) begin
                hist <= {hist[0], rx_s};
                cnt  <= (state == IDLE || (state == START && cnt == 4'd7)) ? 4'd0 : cnt + 4'd1;
            end
            if (baud_x16 && state == IDLE && !rx_s) begin
                {f_bit8, f_par, f_odd} <= {bit8, parity_en, odd_n_even};
                shift   <= '0;
                bit_cnt <= '0;
                perr    <= 1'b0;
            end
            if (baud_x16 && state == DATA && cnt == 4'd15) begin
                shift[bit_cnt] <= smp;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (baud_x16 && state == PARITY && cnt == 4'd15)
                perr <= smp != (^shift ^ f_odd);
            if (load) bus.rx_byte <= shift;
            bus.rx_done     <= stop_pt;
            bus.rx_ready    <= load | (bus.rx_ready & ~bus.rx_read);
            // a flag being set in the same cycle as clr_err stays set
            bus.parity_err  <= (load & perr) | (bus.parity_err & ~bus.clr_err);
            bus.overflow    <= (stop_pt & ~load) | (bus.overflow & ~bus.clr_err);
            bus.framing_err <= (stop_pt & ~smp) | (bus.framing_err & ~bus.clr_err);
        end
endmodule
